// File: rtl/split_pair_adjuster.sv
// split_pair_adjuster
// Half-wide arithmetic sequencer sitting upstream of a split register pair.
// It reads the pair's always-visible value, computes INC / DEC / ADD / SUB,
// and writes the result back over the half-wide B bus: low half first, then
// the high half with the carry from the low half folded in.
//
// Ports:
//   clk        system clock, state updates on posedge
//   rst_n      asynchronous active-low reset
//   start      request pulse, accepted only in IDLE or DONE
//   cmd        0=INC, 1=DEC, 2=ADD offset, 3=SUB offset
//   offset     operand for ADD/SUB (ignored for INC/DEC)
//   pair_in    current pair value from the register
//   bus_b_out  half-result driven onto the register's B input
//   bus_b_low  strobe: register loads bus_b_out into its low half
//   bus_b_high strobe: register loads bus_b_out into its high half
//   busy       high during the LOW and HIGH write cycles
//   done       one-cycle completion pulse
//   carry_out  raw carry out of the high half (SUB: 1 = no borrow)
//   zero       full result equals zero
module split_pair_adjuster #(
  parameter int HALF_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [1:0]                cmd,
  input  logic [2*HALF_WIDTH-1:0]   offset,
  input  logic [2*HALF_WIDTH-1:0]   pair_in,
  output logic [HALF_WIDTH-1:0]     bus_b_out,
  output logic                      bus_b_low,
  output logic                      bus_b_high,
  output logic                      busy,
  output logic                      done,
  output logic                      carry_out,
  output logic                      zero
);

  localparam int PAIR_WIDTH = 2 * HALF_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                  state_r;
  logic [HALF_WIDTH-1:0]   snap_high_r;   // high half of pair_in at accept
  logic [HALF_WIDTH-1:0]   op_high_r;     // high half of the latched operand
  logic [HALF_WIDTH-1:0]   low_res_r;     // low half result, kept for the zero flag
  logic                    low_carry_r;   // carry from the low half into the high half
  logic [HALF_WIDTH-1:0]   bus_b_out_r;
  logic                    bus_b_low_r;
  logic                    bus_b_high_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    carry_out_r;
  logic                    zero_r;

  logic [PAIR_WIDTH-1:0]   operand_s;
  logic                    cin_s;
  logic [HALF_WIDTH:0]     low_sum_s;
  logic [HALF_WIDTH:0]     high_sum_s;

  // Operand / carry-in selection; SUB is add of the one's complement plus one.
  always_comb begin
    operand_s = {PAIR_WIDTH{1'b0}};
    cin_s     = 1'b0;
    case (cmd)
      2'd0: begin
        operand_s = {{(PAIR_WIDTH-1){1'b0}}, 1'b1};
        cin_s     = 1'b0;
      end
      2'd1: begin
        operand_s = {PAIR_WIDTH{1'b1}};
        cin_s     = 1'b0;
      end
      2'd2: begin
        operand_s = offset;
        cin_s     = 1'b0;
      end
      2'd3: begin
        operand_s = ~offset;
        cin_s     = 1'b1;
      end
      default: begin
        operand_s = {PAIR_WIDTH{1'b0}};
        cin_s     = 1'b0;
      end
    endcase
  end

  // Half adders. The low half is computed at accept time from the live pair
  // (identical to the snapshot in that cycle) so bus_b_out can be a register
  // that is already valid throughout the LOW cycle. The high half only ever
  // uses the snapshot, because pair_in changes after the LOW write.
  always_comb begin
    low_sum_s  = {1'b0, pair_in[HALF_WIDTH-1:0]} + {1'b0, operand_s[HALF_WIDTH-1:0]}
               + {{HALF_WIDTH{1'b0}}, cin_s};
    high_sum_s = {1'b0, snap_high_r} + {1'b0, op_high_r}
               + {{HALF_WIDTH{1'b0}}, low_carry_r};
  end

  // Sequencer: IDLE -> LOW -> HIGH -> DONE, all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      snap_high_r  <= {HALF_WIDTH{1'b0}};
      op_high_r    <= {HALF_WIDTH{1'b0}};
      low_res_r    <= {HALF_WIDTH{1'b0}};
      low_carry_r  <= 1'b0;
      bus_b_out_r  <= {HALF_WIDTH{1'b0}};
      bus_b_low_r  <= 1'b0;
      bus_b_high_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      carry_out_r  <= 1'b0;
      zero_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r     <= ST_LOW;
            snap_high_r <= pair_in[PAIR_WIDTH-1:HALF_WIDTH];
            op_high_r   <= operand_s[PAIR_WIDTH-1:HALF_WIDTH];
            low_res_r   <= low_sum_s[HALF_WIDTH-1:0];
            low_carry_r <= low_sum_s[HALF_WIDTH];
            bus_b_out_r <= low_sum_s[HALF_WIDTH-1:0];
            bus_b_low_r <= 1'b1;
            busy_r      <= 1'b1;
            // Flags describe the previous result until a new one starts.
            carry_out_r <= 1'b0;
            zero_r      <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOW: begin
          state_r      <= ST_HIGH;
          bus_b_low_r  <= 1'b0;
          bus_b_high_r <= 1'b1;
          bus_b_out_r  <= high_sum_s[HALF_WIDTH-1:0];
        end
        ST_HIGH: begin
          state_r      <= ST_DONE;
          bus_b_high_r <= 1'b0;
          bus_b_out_r  <= {HALF_WIDTH{1'b0}};
          busy_r       <= 1'b0;
          done_r       <= 1'b1;
          carry_out_r  <= high_sum_s[HALF_WIDTH];
          zero_r       <= (low_res_r == {HALF_WIDTH{1'b0}}) &&
                          (high_sum_s[HALF_WIDTH-1:0] == {HALF_WIDTH{1'b0}});
        end
        default: begin
          state_r      <= ST_IDLE;
          bus_b_low_r  <= 1'b0;
          bus_b_high_r <= 1'b0;
          busy_r       <= 1'b0;
          done_r       <= 1'b0;
        end
      endcase
    end
  end

  assign bus_b_out  = bus_b_out_r;
  assign bus_b_low  = bus_b_low_r;
  assign bus_b_high = bus_b_high_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign carry_out  = carry_out_r;
  assign zero       = zero_r;

endmodule

// File: tb/tb_split_pair_adjuster.sv
module tb_split_pair_adjuster;

  localparam int HW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    cmd;
  logic [7:0]    offset;
  logic [7:0]    reg_pair = 8'h00;
  logic [HW-1:0] bus_b_out;
  logic          bus_b_low;
  logic          bus_b_high;
  logic          busy;
  logic          done;
  logic          carry_out;
  logic          zero;

  logic          preload_en;
  logic [7:0]    preload_val;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] off;
    logic [7:0] init;
    logic [7:0] res;
    logic       c;
    logic       z;
  } vec_t;

  vec_t vecs[9];
  vec_t sb[$];

  split_pair_adjuster #(.HALF_WIDTH(HW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cmd       (cmd),
    .offset    (offset),
    .pair_in   (reg_pair),
    .bus_b_out (bus_b_out),
    .bus_b_low (bus_b_low),
    .bus_b_high(bus_b_high),
    .busy      (busy),
    .done      (done),
    .carry_out (carry_out),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  // Split register model: samples strobes on negedge.
  always @(negedge clk) begin
    if (preload_en) begin
      reg_pair <= preload_val;
    end else begin
      if (bus_b_low)  reg_pair[3:0] <= bus_b_out;
      if (bus_b_high) reg_pair[7:4] <= bus_b_out;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] v);
    @(posedge clk); #1;
    preload_en  = 1'b1;
    preload_val = v;
    @(posedge clk); #1;
    preload_en  = 1'b0;
  endtask

  task automatic issue(input vec_t v);
    start  = 1'b1;
    cmd    = v.cmd;
    offset = v.off;
    sb.push_back(v);
  endtask

  task automatic check_low();
    vec_t e;
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      chk("low_queue_empty", 32'd0, 32'd1);
    end else begin
      e = sb[0];
      chk("low_strobe",  bus_b_low,  1);
      chk("low_no_high", bus_b_high, 0);
      chk("low_busy",    busy,       1);
      chk("low_data",    bus_b_out,  e.res[3:0]);
    end
  endtask

  task automatic check_high();
    vec_t e;
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      chk("high_queue_empty", 32'd0, 32'd1);
    end else begin
      e = sb[0];
      chk("high_strobe", bus_b_high, 1);
      chk("high_no_low", bus_b_low,  0);
      chk("high_busy",   busy,       1);
      chk("high_data",   bus_b_out,  e.res[7:4]);
    end
  endtask

  task automatic check_done();
    vec_t e;
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      chk("done_queue_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("done_pulse",   done,       1);
      chk("done_busy",    busy,       0);
      chk("done_strobes", {bus_b_low, bus_b_high}, 0);
      chk("carry_out",    carry_out,  e.c);
      chk("zero",         zero,       e.z);
      chk("pair_result",  reg_pair,   e.res);
    end
  endtask

  initial begin
    vec_t v;
    // cmd, offset, initial pair, expected pair, carry_out, zero
    vecs[0] = '{2'd0, 8'h00, 8'h0F, 8'h10, 1'b0, 1'b0};  // INC half carry
    vecs[1] = '{2'd0, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b1};  // INC wrap
    vecs[2] = '{2'd1, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0};  // DEC wrap
    vecs[3] = '{2'd2, 8'h27, 8'h3A, 8'h61, 1'b0, 1'b0};  // ADD
    vecs[4] = '{2'd3, 8'h50, 8'h50, 8'h00, 1'b1, 1'b1};  // SUB equal
    vecs[5] = '{2'd3, 8'h20, 8'h10, 8'hF0, 1'b0, 1'b0};  // SUB borrow
    vecs[6] = '{2'd1, 8'h00, 8'h10, 8'h0F, 1'b1, 1'b0};  // DEC half borrow
    vecs[7] = '{2'd2, 8'h5A, 8'hC8, 8'h22, 1'b1, 1'b0};  // ADD overflow
    vecs[8] = '{2'd0, 8'hAA, 8'h00, 8'h01, 1'b0, 1'b0};  // INC ignores offset

    rst_n = 1'b0; start = 1'b0; cmd = 2'd0; offset = 8'h00;
    preload_en = 1'b0; preload_val = 8'h00;
    #2;
    chk("rst_bus_b_out",  bus_b_out,  0);
    chk("rst_strobes",    {bus_b_low, bus_b_high}, 0);
    chk("rst_busy",       busy,       0);
    chk("rst_done",       done,       0);
    chk("rst_flags",      {carry_out, zero}, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      preload(vecs[i].init);
      issue(vecs[i]);
      check_low();
      start = 1'b0;
      check_high();
      check_done();
      @(posedge clk); #1;
      chk("done_one_cycle", done,      0);
      chk("idle_busy",      busy,      0);
      chk("flag_hold",      carry_out, vecs[i].c);
    end

    // start pulses while busy with other commands are ignored
    preload(8'h0F);
    issue(vecs[0]);
    check_low();
    start = 1'b1; cmd = 2'd2; offset = 8'h33;
    check_high();
    cmd = 2'd3; offset = 8'h77;
    check_done();
    start = 1'b0;
    @(posedge clk); #1;
    chk("ignored_no_accept", {busy, bus_b_low}, 0);
    chk("ignored_pair_hold", reg_pair, 8'h10);

    // start held through DONE chains a second INC on the written value
    preload(8'h0F);
    issue(vecs[0]);
    check_low();
    check_high();
    check_done();
    v = '{2'd0, 8'h00, 8'h10, 8'h11, 1'b0, 1'b0};
    issue(v);
    check_low();
    start = 1'b0;
    check_high();
    check_done();

    // reset during the HIGH cycle of INC 0x0F
    preload(8'h0F);
    issue(vecs[0]);
    check_low();
    start = 1'b0;
    @(posedge clk); #3;
    chk("pre_rst_high", bus_b_high, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_strobes", {bus_b_low, bus_b_high}, 0);
    chk("mid_rst_busy",    busy, 0);
    chk("mid_rst_done",    done, 0);
    if (sb.size() != 0) void'(sb.pop_front());
    @(negedge clk); #1;
    chk("mid_rst_pair", reg_pair, 8'h00);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("post_rst_quiet", {bus_b_low, bus_b_high, busy, done}, 0);
    end
    chk("post_rst_pair", reg_pair, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
